// File: rtl/sel_rx_pkg.sv
// Shared types and default constants for the slot-select receiver/synchroniser.
package sel_rx_pkg;

  localparam int unsigned SEL_W = 6;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RUN_W = 8;

  localparam int unsigned NUM_SLOTS_DEF  = 38;
  localparam int unsigned DWELL_DEF      = 101;
  localparam int unsigned DWELL_TOL_DEF  = 2;
  localparam int unsigned LOCK_CNT_DEF   = 4;
  localparam int unsigned UNLOCK_CNT_DEF = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // One-cycle error pulses, kept together so they register as a unit.
  typedef struct packed {
    logic seq;
    logic dwell;
    logic par;
  } err_flags_t;

endpackage

// File: rtl/sel_rx_if.sv
// Receive-side slot-select bus: raw select/parity in, synchronised status out.
interface sel_rx_if;
  import sel_rx_pkg::*;

  logic [SEL_W-1:0] sel_in;
  logic             par_in;
  logic [SEL_W-1:0] slot_idx;
  logic             slot_stb;
  logic             frame_start;
  logic             locked;
  logic             seq_err;
  logic             dwell_err;
  logic             par_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output sel_in, par_in,
    input  slot_idx, slot_stb, frame_start, locked,
    input  seq_err, dwell_err, par_err, err_cnt
  );

  modport slave (
    input  sel_in, par_in,
    output slot_idx, slot_stb, frame_start, locked,
    output seq_err, dwell_err, par_err, err_cnt
  );

endinterface

// File: rtl/sel_rx_edge.sv
// Two-stage capture of select/parity with change and parity-toggle detection.
module sel_rx_edge
  import sel_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             par_in,
  output logic [SEL_W-1:0] sel_s1,
  output logic             chg_c,
  output logic             par_tgl_c
);

  logic [SEL_W-1:0] sel_s1_q, sel_s1_d;
  logic [SEL_W-1:0] sel_s2_q, sel_s2_d;
  logic             par_s1_q, par_s1_d;
  logic             par_s2_q, par_s2_d;

  always_comb begin
    sel_s1_d = sel_in;
    sel_s2_d = sel_s1_q;
    par_s1_d = par_in;
    par_s2_d = par_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      par_s1_q <= 1'b0;
      par_s2_q <= 1'b0;
    end else begin
      sel_s1_q <= sel_s1_d;
      sel_s2_q <= sel_s2_d;
      par_s1_q <= par_s1_d;
      par_s2_q <= par_s2_d;
    end
  end

  assign sel_s1    = sel_s1_q;
  assign chg_c     = (sel_s1_q != sel_s2_q);
  assign par_tgl_c = par_s1_q ^ par_s2_q;

endmodule

// File: rtl/sel_rx_sync.sv
// Slot-select synchroniser: tracks slot sequence and dwell, hunts for and holds lock.
module sel_rx_sync
  import sel_rx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int unsigned DWELL      = DWELL_DEF,
  parameter int unsigned DWELL_TOL  = DWELL_TOL_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  sel_rx_if.slave  bus
);

  localparam int unsigned SUM_W = SEL_W + 1;
  localparam int unsigned LEN_W = CNT_W + 1;

  localparam logic [SUM_W-1:0] NUM_SLOTS_W = SUM_W'(NUM_SLOTS);
  localparam logic [LEN_W-1:0] DWELL_LO    = LEN_W'(DWELL - DWELL_TOL);
  localparam logic [LEN_W-1:0] DWELL_HI    = LEN_W'(DWELL + DWELL_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

  logic [SEL_W-1:0] sel_s1;
  logic             chg_c;
  logic             par_tgl_c;

  sel_rx_edge u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_in    (bus.sel_in),
    .par_in    (bus.par_in),
    .sel_s1    (sel_s1),
    .chg_c     (chg_c),
    .par_tgl_c (par_tgl_c)
  );

  state_e           state_q, state_d;
  logic [SEL_W-1:0] slot_idx_q, slot_idx_d;
  logic             stb_q, stb_d;
  logic             fs_q, fs_d;
  logic             locked_q, locked_d;
  err_flags_t       err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [RUN_W-1:0] good_q, good_d;
  logic [RUN_W-1:0] bad_q, bad_d;

  logic [SUM_W-1:0] slot_sum_c;
  logic [SEL_W-1:0] next_slot_c;
  logic [LEN_W-1:0] dwell_len_c;
  logic             checked_c;
  logic             seq_hit_c;
  logic             dwell_hit_c;
  logic             par_hit_c;
  logic             bad_tr_c;

  // dwell_cnt holds clocks-since-change minus one, so the slot length is cnt+1.
  assign slot_sum_c  = {1'b0, slot_idx_q} + SUM_W'(1);
  assign next_slot_c = (slot_sum_c >= NUM_SLOTS_W) ? SEL_W'(slot_sum_c - NUM_SLOTS_W)
                                                   : SEL_W'(slot_sum_c);
  assign dwell_len_c = {1'b0, dwell_cnt_q} + LEN_W'(1);
  assign checked_c   = chg_c && (state_q != ST_HUNT);
  assign seq_hit_c   = checked_c && (({1'b0, sel_s1} >= NUM_SLOTS_W) || (sel_s1 != next_slot_c));
  assign dwell_hit_c = checked_c && ((dwell_len_c < DWELL_LO) || (dwell_len_c > DWELL_HI));
  assign par_hit_c   = par_tgl_c && !chg_c && (slot_idx_q != '0);
  assign bad_tr_c    = seq_hit_c || dwell_hit_c;

  always_comb begin
    state_d     = state_q;
    slot_idx_d  = slot_idx_q;
    stb_d       = 1'b0;
    fs_d        = 1'b0;
    err_d       = '0;
    err_cnt_d   = err_cnt_q;
    good_d      = good_q;
    bad_d       = bad_q;
    dwell_cnt_d = (dwell_cnt_q == CNT_MAX) ? dwell_cnt_q : dwell_cnt_q + CNT_W'(1);

    err_d.seq   = seq_hit_c;
    err_d.dwell = dwell_hit_c;
    err_d.par   = par_hit_c;

    if (chg_c) begin
      stb_d       = 1'b1;
      slot_idx_d  = sel_s1;
      fs_d        = (sel_s1 == '0);
      dwell_cnt_d = '0;

      unique case (state_q)
        ST_HUNT: begin
          state_d = ST_VERIFY;
          good_d  = '0;
          bad_d   = '0;
        end
        ST_VERIFY: begin
          if (bad_tr_c) begin
            state_d = ST_HUNT;
            good_d  = '0;
          end else if (good_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d  = good_q + RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!bad_tr_c) begin
            bad_d = '0;
          end else if (bad_q == UNLOCK_LAST) begin
            state_d = ST_HUNT;
            bad_d   = '0;
          end else begin
            bad_d   = bad_q + RUN_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // One count per errored cycle, however many flags fire together.
    if ((err_d.seq || err_d.dwell || err_d.par) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      slot_idx_q  <= '0;
      stb_q       <= 1'b0;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
      err_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_idx_q  <= slot_idx_d;
      stb_q       <= stb_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign bus.slot_idx    = slot_idx_q;
  assign bus.slot_stb    = stb_q;
  assign bus.frame_start = fs_q;
  assign bus.locked      = locked_q;
  assign bus.seq_err     = err_q.seq;
  assign bus.dwell_err   = err_q.dwell;
  assign bus.par_err     = err_q.par;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_sel_rx_sync.sv
// Bench for sel_rx_sync: directed scenarios plus randomized slot streams against a slot-level model.
module tb_sel_rx_sync;

  localparam int NS  = 38;
  localparam int DW  = 101;
  localparam int TOL = 2;
  localparam int LCK = 4;
  localparam int ULK = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sel_rx_if bus ();

  sel_rx_sync #(
    .NUM_SLOTS  (NS),
    .DWELL      (DW),
    .DWELL_TOL  (TOL),
    .LOCK_CNT   (LCK),
    .UNLOCK_CNT (ULK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: one entry per slot change, evaluated from slot values and lengths.
  int m_hunt, m_lock, m_good, m_bad, m_err, m_prev;
  int last_len, cur_sel;
  int exp_q[$];
  int fs_cyc[$];
  int cyc = 0;
  int par_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pack(int idx, int fs, int s, int d, int l, int e);
    return (idx << 12) | (fs << 11) | (s << 10) | (d << 9) | (l << 8) | (e & 255);
  endfunction

  function automatic void err_inc();
    if (m_err < 255) m_err = m_err + 1;
  endfunction

  function automatic void model_reset();
    m_hunt = 1; m_lock = 0; m_good = 0; m_bad = 0;
    m_err = 0; m_prev = 0; last_len = 0; cur_sel = 0;
  endfunction

  function automatic void model_change(int v);
    int s, d;
    s = 0; d = 0;
    if (m_hunt != 0) begin
      m_hunt = 0; m_good = 0; m_bad = 0;
    end else begin
      s = ((v >= NS) || (v != (m_prev + 1) % NS)) ? 1 : 0;
      d = ((last_len < DW - TOL) || (last_len > DW + TOL)) ? 1 : 0;
      if (m_lock == 0) begin
        if (s + d > 0) begin
          m_hunt = 1; m_good = 0;
        end else begin
          m_good++;
          if (m_good == LCK) begin m_lock = 1; m_bad = 0; end
        end
      end else if (s + d > 0) begin
        m_bad++;
        if (m_bad == ULK) begin m_lock = 0; m_hunt = 1; m_bad = 0; end
      end else begin
        m_bad = 0;
      end
    end
    if (s + d > 0) err_inc();
    m_prev = v;
    exp_q.push_back(pack(v, (v == 0) ? 1 : 0, s, d, m_lock, m_err));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one slot value for len clocks; slot 0 toggles parity, inj>=0 adds one stray toggle.
  task automatic drive_slot(input int v, input int len, input int inj);
    if (v != cur_sel) model_change(v);
    last_len = len;
    cur_sel = v;
    bus.sel_in = 6'(v);
    for (int k = 0; k < len; k++) begin
      if (v == 0) bus.par_in = ~bus.par_in;
      if (k == inj) begin
        bus.par_in = ~bus.par_in;
        err_inc();
      end
      tick();
    end
  endtask

  task automatic run_to(input int v);
    while (cur_sel != v) drive_slot((cur_sel + 1) % NS, DW, -1);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_slot_idx"}, 32'(bus.slot_idx), 32'd0);
    check_val({pfx, "_stb"},      32'(bus.slot_stb), 32'd0);
    check_val({pfx, "_fs"},       32'(bus.frame_start), 32'd0);
    check_val({pfx, "_locked"},   32'(bus.locked), 32'd0);
    check_val({pfx, "_flags"},    32'({bus.seq_err, bus.dwell_err, bus.par_err}), 32'd0);
    check_val({pfx, "_err_cnt"},  32'(bus.err_cnt), 32'd0);
  endtask

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    int e;
    if (rst_n) begin
      cyc++;
      if (bus.par_err) par_seen++;
      if (bus.frame_start) fs_cyc.push_back(cyc);
      if (bus.slot_stb) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_stb", 32'(bus.slot_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("slot_event",
                    32'(pack(int'(bus.slot_idx), int'(bus.frame_start), int'(bus.seq_err),
                             int'(bus.dwell_err), int'(bus.locked), int'(bus.err_cnt))),
                    32'(e));
        end
      end else if (bus.frame_start || bus.seq_err || bus.dwell_err) begin
        check_val("flag_without_stb", 32'({bus.frame_start, bus.seq_err, bus.dwell_err}), 32'd0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, len, inj, p0;
    rst_n = 1'b0;
    bus.sel_in = '0;
    bus.par_in = 1'b0;
    model_reset();
    repeat (3) tick();
    check_outputs_zero("rst");
    rst_n = 1'b1;

    // Clean stream: three frame starts, 3838 clocks apart, lock after four checked changes.
    drive_slot(0, 20, -1);
    fs_cyc.delete();
    repeat (37 + NS + NS + 1) drive_slot((cur_sel + 1) % NS, DW, -1);
    check_val("frame_count", 32'(fs_cyc.size()), 32'd3);
    for (int i = 1; i < fs_cyc.size(); i++)
      check_val("frame_period", 32'(fs_cyc[i] - fs_cyc[i-1]), 32'(NS * DW));
    check_val("clean_locked", 32'(bus.locked), 32'(m_lock));
    check_val("clean_err_cnt", 32'(bus.err_cnt), 32'(m_err));

    // Two out-of-order values then in-order: bad run of two is cleared, lock held.
    run_to(5);
    drive_slot(7, DW, -1);
    drive_slot(9, DW, -1);
    drive_slot(10, DW, -1);
    drive_slot(11, DW, -1);
    check_val("seq_inject_locked", 32'(bus.locked), 32'(m_lock));

    // Dwell boundaries just inside and outside the tolerance window.
    drive_slot(12, 98, -1);
    drive_slot(13, 99, -1);
    drive_slot(14, 103, -1);
    drive_slot(15, 104, -1);
    drive_slot(16, DW, -1);
    drive_slot(17, DW, -1);
    check_val("dwell_locked", 32'(bus.locked), 32'(m_lock));

    // Three bad in a row drops lock; unchecked change then four good relock.
    drive_slot(25, DW, -1);
    drive_slot(3, DW, -1);
    drive_slot(30, DW, -1);
    check_val("unlock", 32'(bus.locked), 32'(m_lock));
    repeat (6) drive_slot((cur_sel + 1) % NS, DW, -1);
    check_val("relock", 32'(bus.locked), 32'(m_lock));

    // Single stray parity toggle mid-slot.
    run_to(11);
    p0 = par_seen;
    drive_slot(12, DW, 50);
    check_val("par_single", 32'(par_seen - p0), 32'd1);
    check_val("par_err_cnt", 32'(bus.err_cnt), 32'(m_err));
    check_val("par_locked", 32'(bus.locked), 32'(m_lock));

    // Randomized stream: jittered dwell, occasional wild values, stray parity toggles.
    repeat (150) begin
      if ($urandom_range(0, 7) == 0) begin
        do v = int'($urandom_range(0, 63)); while (v == cur_sel);
      end else begin
        v = (cur_sel + 1) % NS;
      end
      len = int'($urandom_range(DW - 5, DW + 5));
      inj = (v != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(10, len - 10)) : -1;
      drive_slot(v, len, inj);
    end
    check_val("rand_err_cnt", 32'(bus.err_cnt), 32'(m_err));

    // Saturate err_cnt with parity errors in slot 20, then reset mid-slot.
    run_to(19);
    drive_slot(20, 10, -1);
    p0 = par_seen;
    repeat (300) begin
      bus.par_in = ~bus.par_in;
      err_inc();
      tick();
    end
    repeat (3) tick();
    check_val("fill_par_count", 32'(par_seen - p0), 32'd300);
    check_val("err_cnt_sat", 32'(bus.err_cnt), 32'(m_err));
    check_val("fill_pending", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) tick();
    model_reset();
    rst_n = 1'b1;
    drive_slot(20, DW, -1);
    repeat (6) drive_slot((cur_sel + 1) % NS, DW, -1);
    check_val("post_rst_locked", 32'(bus.locked), 32'(m_lock));
    check_val("post_rst_err_cnt", 32'(bus.err_cnt), 32'(m_err));

    repeat (5) tick();
    check_val("pending_events", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
